// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and types for the 8-digit memory-mapped 7-segment scan controller.
// The register offsets, the blanked-output code and the hex glyph table live here.
package seg7_scan_ctrl_pkg;

  localparam logic [11:0] DIG_DATA_OFS = 12'h000;
  localparam logic [11:0] DIG_CTRL_OFS = 12'h004;
  localparam logic [7:0]  SEG_OFF      = 8'hFF;

  // Active-low {G,F,E,D,C,B,A}; index is the hex value, lowercase b and d.
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Only the low half of CTRL is stored; the upper 16 bits are ignored on write.
  typedef struct packed {
    logic [7:0] dp_mask;
    logic [7:0] dig_mask;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{dp_mask: 8'h00, dig_mask: 8'hFF};

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit value to active-low 7-segment glyph {G,F,E,D,C,B,A}.
module seg7_hex_decode
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  assign glyph_o = GLYPH[nibble_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Addressable 8-digit 7-segment scan controller: DATA/CTRL registers, scan divider,
// registered active-low outputs. Define SEG7_LZ_BLANK_EN to blank leading-zero digits.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 20000,
  parameter int CNT_W    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [7:0]  led_en,
  output logic [7:0]  led_cx
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      data_q, data_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [7:0]       led_en_q, led_en_d;
  logic [7:0]       led_cx_q, led_cx_d;

  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic             digit_on;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    idx_d  = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end

    data_d = data_q;
    ctrl_d = ctrl_q;
    if (wen && addr == DIG_DATA_OFS) data_d = wdata;
    if (wen && addr == DIG_CTRL_OFS) ctrl_d = wdata[15:0];
  end

  assign nibble = data_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nibble_i (nibble),
    .glyph_o  (glyph)
  );

  // Output is built from the current idx/DATA/CTRL, so a write landing on an idx
  // advance shows up together with the new digit in the next update.
  always_comb begin
    digit_on = ctrl_q.dig_mask[idx_q];
`ifdef SEG7_LZ_BLANK_EN
    if (idx_q != 3'd0 && (data_q >> {idx_q, 2'b00}) == 32'h0) digit_on = 1'b0;
`endif
    led_en_d = SEG_OFF;
    led_cx_d = SEG_OFF;
    if (digit_on) begin
      led_en_d = ~(8'b1 << idx_q);
      led_cx_d = {~ctrl_q.dp_mask[idx_q], glyph};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      ctrl_q   <= CTRL_RST;
      led_en_q <= SEG_OFF;
      led_cx_q <= SEG_OFF;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      led_en_q <= led_en_d;
      led_cx_q <= led_cx_d;
    end
  end

  assign led_en = led_en_q;
  assign led_cx = led_cx_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed steps plus random writes,
// compared against a frame-arithmetic reference model.
module tb_seg7_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int CNT_W    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] addr = '0;
  logic        wen = 1'b0;
  logic [31:0] wdata = '0;
  logic [7:0]  led_en;
  logic [7:0]  led_cx;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Reference state: clock edges since reset release, and the register contents.
  int          edges  = 0;
  logic [31:0] data_m = '0;
  logic [15:0] ctrl_m = 16'h00FF;

  logic [7:0] glyph_tb [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  seg7_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wen    (wen),
    .wdata  (wdata),
    .led_en (led_en),
    .led_cx (led_cx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s (edge %0d): observed %h expected %h", tag, edges, obs, exp);
    end
  endtask

  // Output after an edge shows the digit whose slot contained the previous edge count.
  task automatic model_out(input int e, output logic [7:0] en, output logic [7:0] cx);
    int          idx;
    logic [31:0] upper;
    logic        on;
    idx   = (e / SCAN_DIV) % 8;
    upper = data_m >> (4 * idx);
    on    = ctrl_m[idx];
`ifdef SEG7_LZ_BLANK_EN
    if (idx != 0 && upper == 0) on = 1'b0;
`endif
    en = 8'hFF;
    cx = 8'hFF;
    if (on) begin
      en = ~(8'h01 << idx);
      cx = glyph_tb[upper[3:0]];
      if (ctrl_m[8 + idx]) cx[7] = 1'b0;
    end
  endtask

  task automatic tick(input logic w, input logic [11:0] a, input logic [31:0] d);
    logic [7:0] exp_en, exp_cx;
    wen = w; addr = a; wdata = d;
    @(posedge clk);
    model_out(edges, exp_en, exp_cx);
    if (w && a == 12'h000) data_m = d;
    else if (w && a == 12'h004) ctrl_m = d[15:0];
    edges++;
    #1;
    check("led_en", led_en, exp_en);
    check("led_cx", led_cx, exp_cx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 12'h000, 32'h0);
  endtask

  initial begin
    logic [11:0] ra;
    logic [31:0] rd;

    // Reset held across edges: outputs blanked.
    repeat (2) @(posedge clk);
    #1;
    check("rst_en", led_en, 8'hFF);
    check("rst_cx", led_cx, 8'hFF);
    rst = 1'b1;
    edges = 0;

    // Full frame plus wrap with default registers: FE..7F then FE, glyph '0'.
    idle(33);

    tick(1'b1, 12'h000, 32'h89AB_CDEF);
    idle(32);
    tick(1'b1, 12'h004, 32'h0000_01F0);
    idle(32);
    tick(1'b1, 12'h004, 32'hDEAD_0101);
    idle(32);
    tick(1'b1, 12'h008, 32'h0000_FFFF);
    idle(32);
    tick(1'b1, 12'h004, 32'h0000_A5FF);
    idle(32);

    // Mid-frame async reset at idx=5, cnt=2, with a write in flight.
    while ((edges % (8 * SCAN_DIV)) != 5 * SCAN_DIV + 2) idle(1);
    wen = 1'b1; addr = 12'h000; wdata = 32'h1234_5678;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_en", led_en, 8'hFF);
    check("async_rst_cx", led_cx, 8'hFF);
    @(posedge clk);
    #1;
    check("held_rst_en", led_en, 8'hFF);
    check("held_rst_cx", led_cx, 8'hFF);
    rst = 1'b1;
    edges  = 0;
    data_m = '0;
    ctrl_m = 16'h00FF;
    idle(9);

    // Leading-zero patterns.
    tick(1'b1, 12'h000, 32'h0000_00A0);
    idle(32);
    tick(1'b1, 12'h000, 32'h0000_0000);
    idle(32);
    tick(1'b1, 12'h000, 32'h0030_0000);
    idle(32);

    // Random writes across valid and invalid offsets.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 12'h000;
        1: ra = 12'h004;
        2: ra = 12'h008;
        default: ra = 12'($urandom);
      endcase
      rd = $urandom >> $urandom_range(0, 31);
      tick(($urandom_range(0, 3) == 0), ra, rd);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
